// File: rtl/cordic_vector_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC vectoring core between two channels.
// Handles one job at a time, with a watchdog against a hung core and rejection of illegal modes.
module cordic_vector_arbiter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [1:0]       req1_mode,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_x,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [WIDTH-1:0] rsp0_z,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_x,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [WIDTH-1:0] rsp1_z,
    output logic             rsp1_err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    output logic [WIDTH-1:0] core_angle,
    output logic [1:0]       core_mode,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_rx,
    input  logic [WIDTH-1:0] core_ry,
    input  logic [WIDTH-1:0] core_rz,
    output logic             busy,
    output logic             owner
);

    localparam logic [1:0] ModeCircular = 2'b00;
    localparam logic [1:0] ModeLinear   = 2'b01;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [1:0]       cmode_q, cmode_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic             err_q, err_d;

    logic             grant0, grant1;
    logic [WIDTH-1:0] sel_x, sel_y;
    logic [1:0]       sel_mode;
    logic             rsp_ready_sel;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        wd_d     = wd_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        cmode_d  = cmode_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        rz_d     = rz_q;
        err_d    = err_q;

        // On a tie the channel named by rr_q wins.
        grant0   = (state_q == StIdle) && req0_valid && (!req1_valid || !rr_q);
        grant1   = (state_q == StIdle) && req1_valid && !grant0;
        sel_x    = grant1 ? req1_x : req0_x;
        sel_y    = grant1 ? req1_y : req0_y;
        sel_mode = grant1 ? req1_mode : req0_mode;
        rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;

        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    if (sel_mode == ModeCircular || sel_mode == ModeLinear) begin
                        cx_d    = sel_x;
                        cy_d    = sel_y;
                        cmode_d = sel_mode;
                        state_d = StIssue;
                    end else begin
                        // Illegal mode: answer immediately without touching the core.
                        rx_d    = '0;
                        ry_d    = '0;
                        rz_d    = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (core_done) begin
                    rx_d    = core_rx;
                    ry_d    = core_ry;
                    rz_d    = core_rz;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rx_d    = '0;
                    ry_d    = '0;
                    rz_d    = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_sel) begin
                    rr_d    = ~owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            wd_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cmode_q <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cmode_q <= cmode_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
            err_q   <= err_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp0_x     = rx_q;
    assign rsp0_y     = ry_q;
    assign rsp0_z     = rz_q;
    assign rsp0_err   = err_q;
    assign rsp1_x     = rx_q;
    assign rsp1_y     = ry_q;
    assign rsp1_z     = rz_q;
    assign rsp1_err   = err_q;
    assign core_start = (state_q == StIssue);
    assign core_x     = cx_q;
    assign core_y     = cy_q;
    assign core_angle = '0;
    assign core_mode  = cmode_q;
    assign busy       = (state_q != StIdle);
    assign owner      = owner_q;

endmodule

// File: tb/tb_cordic_vector_arbiter.sv
// Bench for cordic_vector_arbiter: directed scenarios plus randomized jobs checked against
// a transaction-level model of pending requests, round-robin priority and expected results.
module tb_cordic_vector_arbiter;

    localparam int W  = 32;
    localparam int TO = 64;
    localparam logic [1:0] CIRC = 2'b00;
    localparam logic [1:0] LIN  = 2'b01;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 0, req1_valid = 0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [1:0]    req0_mode = '0, req1_mode = '0;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic          rsp0_ready = 0, rsp1_ready = 0;
    logic [W-1:0]  rsp0_x, rsp0_y, rsp0_z, rsp1_x, rsp1_y, rsp1_z;
    logic          core_start, core_done = 0;
    logic [W-1:0]  core_x, core_y, core_angle;
    logic [1:0]    core_mode;
    logic [W-1:0]  core_rx = '0, core_ry = '0, core_rz = '0;
    logic          busy, owner;

    always #5 clock = ~clock;

    cordic_vector_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_mode(req1_mode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_x(rsp0_x), .rsp0_y(rsp0_y),
        .rsp0_z(rsp0_z), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_x(rsp1_x), .rsp1_y(rsp1_y),
        .rsp1_z(rsp1_z), .rsp1_err(rsp1_err),
        .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_angle(core_angle),
        .core_mode(core_mode), .core_done(core_done), .core_rx(core_rx), .core_ry(core_ry),
        .core_rz(core_rz), .busy(busy), .owner(owner)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Model: pending requests per channel and the round-robin priority.
    bit           pv[2];
    logic [W-1:0] px[2], py[2];
    logic [1:0]   pm[2];
    bit           rr;
    int           obs_grants[$];

    task automatic drive_reqs();
        req0_valid = pv[0]; req0_x = px[0]; req0_y = py[0]; req0_mode = pm[0];
        req1_valid = pv[1]; req1_x = px[1]; req1_y = py[1]; req1_mode = pm[1];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_core_x"}, core_x, 0);
        check({tag, "_core_y"}, core_y, 0);
        check({tag, "_core_mode"}, core_mode, 0);
        check({tag, "_core_angle"}, core_angle, 0);
        check({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
        check({tag, "_rsp_data"}, rsp0_x | rsp0_y | rsp0_z | rsp1_x | rsp1_y | rsp1_z, 0);
        check({tag, "_rsp_err"}, {rsp0_err, rsp1_err}, 0);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pv[0] = 0; pv[1] = 0; rr = 0;
        drive_reqs();
        core_done = 0; rsp0_ready = 0; rsp1_ready = 0;
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [1:0] m);
        pv[ch] = 1; px[ch] = x; py[ch] = y; pm[ch] = m;
    endtask

    // One job from arbitration to response handshake. delay<0: core never finishes.
    task automatic run_job(input int delay, input int stall);
        int           w;
        bit           legal;
        logic [W-1:0] jx, jy, ex, ey, ez;
        logic [1:0]   jm;
        logic         eerr;
        @(negedge clock);
        drive_reqs();
        core_done = 0; rsp0_ready = 0; rsp1_ready = 0;
        #1;
        w = (pv[0] && pv[1]) ? int'(rr) : (pv[0] ? 0 : 1);
        check("idle_busy", busy, 0);
        check("grant0", req0_ready, (w == 0));
        check("grant1", req1_ready, (w == 1));
        obs_grants.push_back(req1_ready ? 1 : 0);
        jx = px[w]; jy = py[w]; jm = pm[w];
        legal = (jm == CIRC) || (jm == LIN);
        pv[w] = 0;

        @(negedge clock);
        drive_reqs();
        #1;
        check("owner", owner, w);
        check("busy_ready", {req0_ready, req1_ready}, 0);
        if (!legal) begin
            ex = '0; ey = '0; ez = '0; eerr = 1;
            check("illegal_no_start", core_start, 0);
        end else begin
            ex = '0; ey = '0; ez = '0; eerr = 1;
            check("start", core_start, 1);
            check("core_x", core_x, jx);
            check("core_y", core_y, jy);
            check("core_mode", core_mode, jm);
            check("core_angle", core_angle, 0);
            for (int k = 0; k < TO; k++) begin
                @(negedge clock);
                core_done = (k == delay);
                core_rx = $urandom; core_ry = $urandom; core_rz = $urandom;
                if (core_done) begin
                    ex = core_rx; ey = core_ry; ez = core_rz; eerr = 0;
                end
                #1;
                check("wait_start_low", core_start, 0);
                check("wait_no_rsp", {rsp0_valid, rsp1_valid}, 0);
                check("wait_hold", {core_x ^ jx} | {core_y ^ jy} | core_mode ^ jm, 0);
                if (k == delay) break;
            end
            @(negedge clock);
            core_done = 0;
            #1;
        end

        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(negedge clock);
                // A late done while responding must not disturb the result.
                core_done = (s == 1);
                core_rx = $urandom; core_ry = $urandom; core_rz = $urandom;
                #1;
            end
            check("rsp_valid_own", w ? rsp1_valid : rsp0_valid, 1);
            check("rsp_valid_other", w ? rsp0_valid : rsp1_valid, 0);
            check("rsp_x", w ? rsp1_x : rsp0_x, ex);
            check("rsp_y", w ? rsp1_y : rsp0_y, ey);
            check("rsp_z", w ? rsp1_z : rsp0_z, ez);
            check("rsp_err", w ? rsp1_err : rsp0_err, eerr);
            check("rsp_no_accept", {req0_ready, req1_ready}, 0);
        end
        core_done = 0;
        if (w == 1) rsp1_ready = 1; else rsp0_ready = 1;
        rr = (w == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ch, dly, stl;
        do_reset();

        // Channel 0 alone, core answers after 16 WAIT cycles.
        set_req(0, 32'h0001_0000, 32'h0001_0000, CIRC);
        run_job(16, 0);

        // Simultaneous requests from reset: grant order 0, 1, 0.
        do_reset();
        obs_grants.delete();
        set_req(0, $urandom, $urandom, CIRC);
        set_req(1, $urandom, $urandom, LIN);
        run_job(2, 0);
        set_req(0, $urandom, $urandom, CIRC);
        run_job(5, 1);
        set_req(1, $urandom, $urandom, LIN);
        run_job(1, 0);
        check("order_0", obs_grants[0], 0);
        check("order_1", obs_grants[1], 1);
        check("order_2", obs_grants[2], 0);

        // Hung core on channel 1, then a normal job.
        set_req(1, $urandom, $urandom, LIN);
        run_job(-1, 0);
        set_req(1, $urandom, $urandom, CIRC);
        run_job(3, 0);
        // Boundary: done in the final watchdog cycle wins.
        set_req(0, $urandom, $urandom, LIN);
        run_job(TO - 1, 0);

        // Illegal mode.
        set_req(0, $urandom, $urandom, 2'b11);
        run_job(0, 0);

        // Long back-pressure on channel 0 with channel 1 waiting.
        do_reset();
        set_req(0, $urandom, $urandom, CIRC);
        set_req(1, $urandom, $urandom, CIRC);
        run_job(3, 20);
        run_job(4, 0);

        // Reset during WAIT, then a stale done in IDLE.
        set_req(0, $urandom, $urandom, CIRC);
        @(negedge clock);
        drive_reqs(); rsp0_ready = 0; rsp1_ready = 0;
        #1;
        check("mid_accept", req0_ready, 1);
        pv[0] = 0;
        @(negedge clock);
        drive_reqs();
        repeat (3) @(negedge clock);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        rr = 0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        core_done = 1; core_rx = $urandom;
        #1;
        check("stale_busy", busy, 0);
        check("stale_rsp", {rsp0_valid, rsp1_valid}, 0);
        @(negedge clock);
        core_done = 0;
        #1;
        check_all_zero("after_stale");

        // Randomized jobs.
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pv[c] && $urandom_range(0, 9) < 6)
                    set_req(c, $urandom, $urandom,
                            ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                                        : 2'($urandom_range(0, 1)));
            end
            if (!pv[0] && !pv[1]) begin
                ch = $urandom_range(0, 1);
                set_req(ch, $urandom, $urandom, 2'($urandom_range(0, 1)));
            end
            case ($urandom_range(0, 19))
                0, 1, 2: dly = -1;
                3, 4:    dly = TO - 1;
                default: dly = $urandom_range(0, 20);
            endcase
            stl = $urandom_range(0, 3);
            run_job(dly, stl);
        end

        @(negedge clock);
        rsp0_ready = 0; rsp1_ready = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
